// File: rtl/dmem_port_if.sv
// Memory-side bus of the data-memory port: request/address/data out, ack/read data back.
// The master modport is the pipeline port and the slave modport is the memory.
interface dmem_port_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_port.sv
// MEM-stage data-memory port: lane steering for stores, extension for loads, pipeline
// stall while the memory answers, misalignment detection and an ack timeout.
module dmem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreqM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic [1:0]  swhbM,
  input  logic [1:0]  lwhbM,
  input  logic        luM,
  output logic [31:0] rdataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        buserrM,
  dmem_port_if.master mem
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d;
  logic        lu_q, lu_d;
  logic        we_q, we_d;

  logic [1:0]  size_in;
  logic        valid_in;
  logic        misal_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  always_comb begin
    size_in  = memwriteM ? swhbM : lwhbM;
    valid_in = memreqM && (size_in != 2'b00);
    misal_in = ((size_in == 2'b10) && addrM[0]) ||
               ((size_in == 2'b11) && (addrM[1:0] != 2'b00));
    be_in    = 4'b0000;
    wdata_in = wdataM;
    case (size_in)
      2'b01: begin
        be_in    = 4'b0001 << addrM[1:0];
        wdata_in = {4{wdataM[7:0]}};
      end
      2'b10: begin
        be_in    = addrM[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{wdataM[15:0]}};
      end
      2'b11:   be_in = 4'b1111;
      default: be_in = 4'b0000;
    endcase
    if (!memwriteM) be_in = 4'b0000;
  end

  // Load lane selection works from the offset registered at request time.
  always_comb begin
    lane_b = cap_q[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? cap_q[31:16] : cap_q[15:0];
    case (size_q)
      2'b01:   load_val = lu_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b10:   load_val = lu_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = cap_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cap_d         = cap_q;
    hold_d        = hold_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    size_d        = size_q;
    lu_d          = lu_q;
    we_d          = we_q;
    stallM        = 1'b0;
    misalignM     = 1'b0;
    buserrM       = 1'b0;
    rdataM        = hold_q;
    mem.mem_req   = 1'b0;
    mem.mem_we    = we_q;
    mem.mem_addr  = {addr_q[31:2], 2'b00};
    mem.mem_be    = be_q;
    mem.mem_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (valid_in && misal_in) begin
          misalignM = 1'b1;
        end else if (valid_in) begin
          stallM        = 1'b1;
          mem.mem_req   = 1'b1;
          mem.mem_we    = memwriteM;
          mem.mem_addr  = {addrM[31:2], 2'b00};
          mem.mem_be    = be_in;
          mem.mem_wdata = wdata_in;
          addr_d        = addrM;
          wdata_d       = wdata_in;
          be_d          = be_in;
          size_d        = size_in;
          lu_d          = luM;
          we_d          = memwriteM;
          cnt_d         = 8'd0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        stallM      = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          cap_d   = mem.mem_rdata;
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          buserrM     = 1'b1;
          mem.mem_req = 1'b0;
          cap_d       = 32'd0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!we_q) begin
          rdataM = load_val;
          hold_d = load_val;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet while reset is held, even before the edge lands.
    if (reset) begin
      stallM        = 1'b0;
      misalignM     = 1'b0;
      buserrM       = 1'b0;
      rdataM        = 32'd0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = 32'd0;
      mem.mem_be    = 4'd0;
      mem.mem_wdata = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cap_q   <= 32'd0;
      hold_q  <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      size_q  <= 2'd0;
      lu_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
      lu_q    <= lu_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// Scenario bench for dmem_port: a scoreboard queue holds expected rdataM values pushed at
// request time and popped in the DONE cycle, while each scenario checks the bus inline.
module tb_dmem_port;

  logic        clk;
  logic        reset;
  logic        memreqM;
  logic        memwriteM;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic [1:0]  swhbM;
  logic [1:0]  lwhbM;
  logic        luM;
  logic [31:0] rdataM;
  logic        stallM;
  logic        misalignM;
  logic        buserrM;

  dmem_port_if mem_bus ();

  dmem_port #(.TIMEOUT(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .memreqM   (memreqM),
    .memwriteM (memwriteM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .swhbM     (swhbM),
    .lwhbM     (lwhbM),
    .luM       (luM),
    .rdataM    (rdataM),
    .stallM    (stallM),
    .misalignM (misalignM),
    .buserrM   (buserrM),
    .mem       (mem_bus)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] sb[$];
  logic [31:0] last_rdata = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The unused size code gets a value that would behave differently if wrongly selected.
  task automatic set_req(input logic we, input logic [1:0] size, input logic lu,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic [1:0] junk;
    junk      = (size == 2'b11) ? 2'b01 : 2'b11;
    memreqM   = 1'b1;
    memwriteM = we;
    swhbM     = we ? size : junk;
    lwhbM     = we ? junk : size;
    luM       = lu;
    addrM     = addr;
    wdataM    = wd;
  endtask

  task automatic clear_req();
    memreqM   = 1'b0;
    memwriteM = 1'b0;
    swhbM     = 2'b00;
    lwhbM     = 2'b00;
    luM       = 1'b0;
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic lu,
                                             input logic [1:0] off, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> (off * 8);
    case (size)
      2'b01:   return lu ? (sh & 32'h0000_00FF) : {{24{sh[7]}}, sh[7:0]};
      2'b10:   return lu ? (sh & 32'h0000_FFFF) : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return 4'b0001 << off;
      2'b10:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b01:   return {24'b0, d[7:0]} * 32'h0101_0101;
      2'b10:   return {16'b0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1;
    set_req(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    tests_run++;
    if (mem_bus.mem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_req: got %0b expected 0", mem_bus.mem_req);
    end
    tests_run++;
    if ({stallM, misalignM, buserrM} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {stallM, misalignM, buserrM});
    end
    tests_run++;
    if ({rdataM, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: got rdata=%h we=%b be=%b addr=%h wdata=%h expected all 0",
               rdataM, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    clear_req();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    reset = 1'b0;
    tick();
    exp = 32'd0;
    last_rdata = exp;
  endtask

  task automatic test_load_byte();
    int          stall_cnt;
    logic [31:0] exp;
    sb.push_back(32'hFFFF_FF80);
    set_req(1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0);
    #1;
    stall_cnt = (stallM === 1'b1) ? 1 : 0;
    tests_run++;
    if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be} !== {1'b1, 1'b0, 4'b0000}) begin
      tests_failed++;
      $display("[TB] FAIL lb_req: got req=%b we=%b be=%b expected req=1 we=0 be=0000",
               mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be);
    end
    tests_run++;
    if (mem_bus.mem_addr !== 32'h0000_0100) begin
      tests_failed++;
      $display("[TB] FAIL lb_addr: got %h expected 00000100", mem_bus.mem_addr);
    end
    tick();
    addrM = 32'hDEAD_BEEF;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h80AA_BBCC;
    #1;
    if (stallM === 1'b1) stall_cnt++;
    tests_run++;
    if (mem_bus.mem_addr !== 32'h0000_0100 || mem_bus.mem_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL lb_wait_hold: got req=%b addr=%h expected req=1 addr=00000100",
               mem_bus.mem_req, mem_bus.mem_addr);
    end
    tick();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    #1;
    if (stallM === 1'b1) stall_cnt++;
    exp = sb.pop_front();
    tests_run++;
    if (rdataM !== exp) begin
      tests_failed++;
      $display("[TB] FAIL lb_rdata: got %h expected %h", rdataM, exp);
    end
    tests_run++;
    if (mem_bus.mem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lb_done_ignores_req: got req=%b expected 0", mem_bus.mem_req);
    end
    tests_run++;
    if (stall_cnt != 2) begin
      tests_failed++;
      $display("[TB] FAIL lb_stall_cycles: got %0d expected 2", stall_cnt);
    end
    last_rdata = exp;
    clear_req();
    tick();
    tests_run++;
    if (rdataM !== last_rdata) begin
      tests_failed++;
      $display("[TB] FAIL lb_rdata_hold: got %h expected %h", rdataM, last_rdata);
    end
  endtask

  task automatic test_store_half();
    logic [31:0] exp;
    sb.push_back(last_rdata);
    set_req(1'b1, 2'b10, 1'b0, 32'h0000_0202, 32'h1234_ABCD);
    #1;
    tests_run++;
    if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_wdata, mem_bus.mem_addr}
        !== {1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0200}) begin
      tests_failed++;
      $display("[TB] FAIL sh_req: got req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 1100 abcdabcd 00000200",
               mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_wdata, mem_bus.mem_addr);
    end
    for (int w = 1; w <= 2; w++) begin
      tick();
      addrM  = 32'h0000_0001 + w;
      wdataM = 32'h0;
      if (w == 2) begin
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h5555_5555;
      end
      #1;
      tests_run++;
      if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_wdata, mem_bus.mem_addr, stallM}
          !== {1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0200, 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL sh_wait%0d_hold: got req=%b we=%b be=%b wdata=%h addr=%h stall=%b expected 1 1 1100 abcdabcd 00000200 1",
                 w, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_wdata,
                 mem_bus.mem_addr, stallM);
      end
    end
    tick();
    mem_bus.mem_ack = 1'b0;
    #1;
    exp = sb.pop_front();
    tests_run++;
    if (rdataM !== exp || stallM !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sh_done: got rdata=%h stall=%b expected rdata=%h stall=0", rdataM, stallM, exp);
    end
    clear_req();
    tick();
  endtask

  task automatic test_misalign();
    set_req(1'b0, 2'b11, 1'b0, 32'h0000_0006, 32'h0);
    #1;
    tests_run++;
    if ({misalignM, mem_bus.mem_req, stallM} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL lw_misalign: got misalign=%b req=%b stall=%b expected 1 0 0",
               misalignM, mem_bus.mem_req, stallM);
    end
    clear_req();
    tick();
    tests_run++;
    if ({misalignM, mem_bus.mem_req, stallM} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL lw_misalign_pulse: got misalign=%b req=%b stall=%b expected 0 0 0",
               misalignM, mem_bus.mem_req, stallM);
    end
    set_req(1'b1, 2'b10, 1'b0, 32'h0000_0011, 32'h0);
    #1;
    tests_run++;
    if ({misalignM, mem_bus.mem_req} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL sh_misalign: got misalign=%b req=%b expected 1 0", misalignM, mem_bus.mem_req);
    end
    clear_req();
    tick();
  endtask

  task automatic test_timeout();
    int          wait_cycles;
    logic [31:0] exp;
    sb.push_back(32'd0);
    set_req(1'b0, 2'b10, 1'b1, 32'h0000_0040, 32'h0);
    tick();
    wait_cycles = 0;
    while (buserrM !== 1'b1 && wait_cycles < 400) begin
      if (mem_bus.mem_req === 1'b1) wait_cycles++;
      tick();
    end
    tests_run++;
    if (buserrM !== 1'b1 || wait_cycles != 255) begin
      tests_failed++;
      $display("[TB] FAIL timeout_cycles: got buserr=%b after %0d wait cycles expected buserr=1 after 255",
               buserrM, wait_cycles);
    end
    tests_run++;
    if (mem_bus.mem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_req_drop: got req=%b expected 0", mem_bus.mem_req);
    end
    tick();
    exp = sb.pop_front();
    tests_run++;
    if ({buserrM, stallM} !== 2'b00 || rdataM !== exp) begin
      tests_failed++;
      $display("[TB] FAIL timeout_done: got buserr=%b stall=%b rdata=%h expected 0 0 %h",
               buserrM, stallM, rdataM, exp);
    end
    last_rdata = exp;
    clear_req();
    tick();
    tests_run++;
    if (rdataM !== last_rdata || mem_bus.mem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_idle: got rdata=%h req=%b expected %h 0", rdataM, mem_bus.mem_req, last_rdata);
    end
  endtask

  task automatic test_ack_at_timeout();
    logic [31:0] exp;
    sb.push_back(32'hFFFF_8001);
    set_req(1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'h0);
    tick();
    repeat (255) tick();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h8001_7FFF;
    #1;
    tests_run++;
    if ({buserrM, mem_bus.mem_req} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL ack_wins: got buserr=%b req=%b expected 0 1", buserrM, mem_bus.mem_req);
    end
    tick();
    mem_bus.mem_ack = 1'b0;
    #1;
    exp = sb.pop_front();
    tests_run++;
    if (rdataM !== exp || buserrM !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ack_wins_rdata: got rdata=%h buserr=%b expected %h 0", rdataM, buserrM, exp);
    end
    last_rdata = exp;
    clear_req();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    sb.push_back(last_rdata);
    set_req(1'b1, 2'b11, 1'b0, 32'h0000_0300, 32'hCAFE_F00D);
    #1;
    tests_run++;
    if ({mem_bus.mem_be, mem_bus.mem_wdata} !== {4'b1111, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_sw: got be=%b wdata=%h expected 1111 cafef00d", mem_bus.mem_be, mem_bus.mem_wdata);
    end
    tick();
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    set_req(1'b0, 2'b11, 1'b0, 32'h0000_0304, 32'h0);
    #1;
    exp = sb.pop_front();
    tests_run++;
    if (mem_bus.mem_req !== 1'b0 || rdataM !== exp) begin
      tests_failed++;
      $display("[TB] FAIL b2b_done: got req=%b rdata=%h expected 0 %h", mem_bus.mem_req, rdataM, exp);
    end
    sb.push_back(32'h0BAD_F00D);
    tick();
    tests_run++;
    if ({mem_bus.mem_req, stallM, mem_bus.mem_we, mem_bus.mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h0000_0304}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_lw_req: got req=%b stall=%b we=%b addr=%h expected 1 1 0 00000304",
               mem_bus.mem_req, stallM, mem_bus.mem_we, mem_bus.mem_addr);
    end
    tick();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_bus.mem_ack = 1'b0;
    #1;
    exp = sb.pop_front();
    tests_run++;
    if (rdataM !== exp) begin
      tests_failed++;
      $display("[TB] FAIL b2b_lw_rdata: got %h expected %h", rdataM, exp);
    end
    last_rdata = exp;
    clear_req();
    tick();
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 10; i++) begin
      logic        we;
      logic        lu;
      logic [1:0]  size;
      logic [1:0]  off;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [31:0] exp;
      int          waits;
      we    = 1'($urandom_range(0, 1));
      lu    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(1, 3));
      off   = 2'($urandom_range(0, 3));
      if (size == 2'b11) off = 2'b00;
      if (size == 2'b10) off[0] = 1'b0;
      addr  = $urandom();
      addr[1:0] = off;
      wd    = $urandom();
      rd    = $urandom();
      waits = $urandom_range(1, 3);
      sb.push_back(we ? last_rdata : model_load(size, lu, off, rd));
      set_req(we, size, lu, addr, wd);
      #1;
      tests_run++;
      if (mem_bus.mem_addr !== {addr[31:2], 2'b00} ||
          mem_bus.mem_be !== (we ? model_be(size, off) : 4'b0000) ||
          (we && mem_bus.mem_wdata !== model_wdata(size, wd))) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_req: got addr=%h be=%b wdata=%h expected addr=%h be=%b wdata=%h",
                 i, mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata, {addr[31:2], 2'b00},
                 we ? model_be(size, off) : 4'b0000, model_wdata(size, wd));
      end
      tick();
      for (int w = 1; w < waits; w++) tick();
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = rd;
      tick();
      mem_bus.mem_ack = 1'b0;
      #1;
      exp = sb.pop_front();
      tests_run++;
      if (rdataM !== exp || stallM !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_rdata: got rdata=%h stall=%b expected %h 0 (we=%b size=%b lu=%b off=%0d)",
                 i, rdataM, stallM, exp, we, size, lu, off);
      end
      last_rdata = exp;
      clear_req();
      tick();
    end
  endtask

  task automatic test_reset_in_wait();
    set_req(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    clear_req();
    #1;
    tests_run++;
    if ({mem_bus.mem_req, stallM, rdataM, mem_bus.mem_addr} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_outputs: got req=%b stall=%b rdata=%h addr=%h expected all 0",
               mem_bus.mem_req, stallM, rdataM, mem_bus.mem_addr);
    end
    tick();
    reset = 1'b0;
    tick();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h1234_5678;
    #1;
    tests_run++;
    if ({mem_bus.mem_req, stallM, rdataM} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_idle: got req=%b stall=%b rdata=%h expected 0 0 0",
               mem_bus.mem_req, stallM, rdataM);
    end
    tick();
    mem_bus.mem_ack = 1'b0;
    #1;
    tests_run++;
    if ({mem_bus.mem_req, stallM, buserrM, rdataM} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_ack_ignored: got req=%b stall=%b buserr=%b rdata=%h expected all 0",
               mem_bus.mem_req, stallM, buserrM, rdataM);
    end
    last_rdata = 32'd0;
    tick();
  endtask

  initial begin
    reset             = 1'b1;
    memreqM           = 1'b0;
    memwriteM         = 1'b0;
    addrM             = 32'd0;
    wdataM            = 32'd0;
    swhbM             = 2'b00;
    lwhbM             = 2'b00;
    luM               = 1'b0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_random_mix();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
